hsv_match_multi: RTL and testbench
==================================

# hsv_match_multi

Pipelined multi-target HSV colour matcher with per-channel thresholds, hue wrap-around handling, frame-synchronous configuration and an on-line "learn" capture of target colours. Sits in the video path directly after the RGB→HSV converter. Produces a binary object mask plus per-target match flags for the downstream morphology/centroid blocks. Supports NUM_REF simultaneous colour targets, each individually enabled.

## Interface

- NUM_REF, 4, number of colour targets (1..8)
- DW, 8, bits per H/S/V component
- HUE_MOD, 256, hue period; hue values lie in 0..HUE_MOD-1
- H_SHIFT, 1, right-shift applied to hue distance (weight)
- SV_SHIFT, 2, right-shift applied to S and V distances
- XW, 11, pixel column counter width
- YW, 11, pixel row counter width

- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- in_valid  in  1  pixel qualifier
- in_vs  in  1  vertical sync, active-high, frame start
- in_hs  in  1  horizontal sync, active-high, line start
- in_hsv  in  3*DW  {H,S,V}
- cfg_we  in  1  write target cfg_idx into shadow bank
- cfg_idx  in  3  target index (only log2(NUM_REF) LSBs used)
- cfg_hsv  in  3*DW  target colour
- cfg_en  in  1  target enable
- thr_sum  in  DW+2  sum threshold (shadowed)
- thr_h, thr_s, thr_v  in  DW each  channel thresholds (shadowed)
- learn_req  in  1  pulse: arm capture into target learn_idx
- learn_idx  in  3  target to learn
- learn_x  in  XW  capture column
- learn_y  in  YW  capture row
- out_valid, out_vs, out_hs  out  1 each  delayed in_valid/in_vs/in_hs
- out_bin  out  1  1 = pixel matches any enabled target
- out_match  out  NUM_REF  per-target match flags
- out_idx  out  3  lowest matching target index, 0 if none
- learn_busy  out  1  capture armed, not yet done
- learn_done  out  1  one-cycle pulse when capture is written

## Operation

- Two banks of targets and thresholds: shadow (written by cfg_we/learn) and active (used by datapath). Active ← shadow on the cycle after an in_vs rising edge. Thresholds are sampled into active at the same instant.
- Counters: x clears when in_hs=1, increments on each in_valid. y clears when in_vs=1, increments on in_hs rising edge; first line is y=0.
- Learn: learn_req sets learn_busy and latches learn_idx/x/y. The first in_valid with x==learn_x and y==learn_y writes in_hsv into shadow target learn_idx and sets its enable. Next cycle: learn_done=1 for one cycle, learn_busy=0. learn_req while busy re-arms with the new coordinates.
- cfg_we and a learn write to the same index in the same cycle: learn wins. Different indices: both take effect.
- Distance per target: dS,dV = |a−b| (DW bits). dH = |a−b| folded: if d > HUE_MOD/2 then HUE_MOD−d.
- Weighted: wH=dH>>H_SHIFT, wS=dS>>SV_SHIFT, wV=dV>>SV_SHIFT. sum=wH+wS+wV, DW+2 bits, no overflow.
- Match: enabled AND sum ≤ thr_sum AND wH ≤ thr_h AND wS ≤ thr_s AND wV ≤ thr_v. Any strict exceedance means no match.
- out_bin = OR(out_match). out_idx = priority encode of out_match, lowest index first.
- Outputs are forced 0 when the corresponding out_valid=0, except out_vs and out_hs, which always follow their delayed inputs.

## Timing

- Latency 3 cycles, throughput 1 pixel/clock.
  - S1: distances registered.
  - S2: weights and sums registered.
  - S3: compare, OR, priority encode registered.
- in_valid/vs/hs are delayed by 3 alongside the data.
- Bank swap occurs between frames; pixels already in the pipe use the bank captured at S1 entry. The swap cycle carries no valid pixel by sync protocol.
- Reset: all outputs 0; pipeline, counters, both banks, thresholds and learn state cleared. All targets are disabled, so out_bin=0 until the first configuration plus vs edge. Reset mid-frame discards in-flight pixels.
- x/y wrap silently at 2^XW/2^YW.

## Test plan

- Single target H=100,S=128,V=128, thr_sum=20, thr_h=6, thr_s=thr_v=12, after vs. Pixel (110,128,128) → out_bin=1 (wH=5) exactly 3 clocks later. Pixel (114,128,128) → 0 (wH=7).
- Hue wrap: target H=250, pixel H=4, HUE_MOD=256 → dH=10, wH=5, out_bin=1. Pixel H=20 → dH=26, wH=13, out_bin=0.
- Two targets both matching (idx 1 and 3) → out_match=4'b1010, out_idx=1. Disabling idx1 via cfg_we mid-frame → unchanged until next vs, then out_idx=3.
- Sum boundary: wH=6, wS=12, wV=2 → sum=20 → match. Raising wV to 3 → sum=21 → no match.
- Learn: learn_req idx2 at (5,3). Pixel (5,3)=(40,200,90) → learn_done one cycle after that pixel. After next vs, an identical pixel gives out_match[2]=1. Simultaneous cfg_we idx2 in the same cycle is ignored.
- Assert rst_n low mid-line with data in flight → all outputs 0 immediately. After release, no stale pixels appear and all targets are disabled.

Source files
------------

// File: rtl/hsv_match_multi_if.sv
// Pixel stream into hsv_match_multi and the per-pixel match results coming out.
interface hsv_match_multi_if #(
   parameter int NUM_REF = 4,
   parameter int DW      = 8
);
   logic               in_valid;
   logic               in_vs;
   logic               in_hs;
   logic [3*DW-1:0]    in_hsv;
   logic               out_valid;
   logic               out_vs;
   logic               out_hs;
   logic               out_bin;
   logic [NUM_REF-1:0] out_match;
   logic [2:0]         out_idx;

   modport master (output in_valid, in_vs, in_hs, in_hsv,
                   input  out_valid, out_vs, out_hs, out_bin, out_match, out_idx);
   modport slave  (input  in_valid, in_vs, in_hs, in_hsv,
                   output out_valid, out_vs, out_hs, out_bin, out_match, out_idx);
endinterface

// File: rtl/hsv_match_multi.sv
// Three-stage multi-target HSV matcher with frame-synchronous shadow/active
// target banks and on-line learn capture of a target colour at a pixel position.
module hsv_match_multi #(
   parameter int NUM_REF  = 4,
   parameter int DW       = 8,
   parameter int HUE_MOD  = 256,
   parameter int H_SHIFT  = 1,
   parameter int SV_SHIFT = 2,
   parameter int XW       = 11,
   parameter int YW       = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hsv_match_multi_if.slave     vid,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_idx,
   input  logic [3*DW-1:0]      cfg_hsv,
   input  logic                 cfg_en,
   input  logic [DW+1:0]        thr_sum,
   input  logic [DW-1:0]        thr_h,
   input  logic [DW-1:0]        thr_s,
   input  logic [DW-1:0]        thr_v,
   input  logic                 learn_req,
   input  logic [2:0]           learn_idx,
   input  logic [XW-1:0]        learn_x,
   input  logic [YW-1:0]        learn_y,
   output logic                 learn_busy,
   output logic                 learn_done
);
   localparam logic [2:0]  IDX_MASK = 3'((1 << $clog2(NUM_REF)) - 1);
   localparam logic [DW:0] HMOD     = (DW+1)'(HUE_MOD);
   localparam logic [DW:0] HALF     = (DW+1)'(HUE_MOD / 2);

   typedef struct packed {
      logic [DW+1:0] sum;
      logic [DW-1:0] h;
      logic [DW-1:0] s;
      logic [DW-1:0] v;
   } thr_t;

   function automatic logic [DW-1:0] absdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   logic          vs_d, hs_d, swap_q, line_seen;
   logic          vs_rise, hs_rise, learn_hit;
   logic [XW-1:0] x_cnt, l_x;
   logic [YW-1:0] y_cnt, l_y;
   logic [2:0]    l_idx, cfg_sel;

   logic [NUM_REF-1:0][3*DW-1:0] sh_hsv, act_hsv;
   logic [NUM_REF-1:0]           sh_en, act_en;
   thr_t                         act_thr;

   assign vs_rise   = vid.in_vs & ~vs_d;
   assign hs_rise   = vid.in_hs & ~hs_d;
   assign cfg_sel   = cfg_idx & IDX_MASK;
   assign learn_hit = learn_busy & vid.in_valid & (x_cnt == l_x) & (y_cnt == l_y);

   // The first hs after vs opens line 0; later hs rising edges advance y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d      <= 1'b0;
         hs_d      <= 1'b0;
         swap_q    <= 1'b0;
         line_seen <= 1'b0;
         x_cnt     <= '0;
         y_cnt     <= '0;
      end else begin
         vs_d   <= vid.in_vs;
         hs_d   <= vid.in_hs;
         swap_q <= vs_rise;
         if (vid.in_hs)
            x_cnt <= '0;
         else if (vid.in_valid)
            x_cnt <= x_cnt + XW'(1);
         if (vid.in_vs) begin
            y_cnt     <= '0;
            line_seen <= 1'b0;
         end else if (hs_rise) begin
            if (line_seen)
               y_cnt <= y_cnt + YW'(1);
            line_seen <= 1'b1;
         end
      end
   end

   // Learn capture overrides a same-cycle cfg write to the same target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         learn_busy <= 1'b0;
         learn_done <= 1'b0;
         l_idx      <= '0;
         l_x        <= '0;
         l_y        <= '0;
         sh_hsv     <= '0;
         sh_en      <= '0;
         act_hsv    <= '0;
         act_en     <= '0;
         act_thr    <= '0;
      end else begin
         learn_done <= learn_hit;
         if (learn_req) begin
            learn_busy <= 1'b1;
            l_idx      <= learn_idx & IDX_MASK;
            l_x        <= learn_x;
            l_y        <= learn_y;
         end else if (learn_hit) begin
            learn_busy <= 1'b0;
         end
         for (int i = 0; i < NUM_REF; i++) begin
            if (learn_hit && l_idx == 3'(i)) begin
               sh_hsv[i] <= vid.in_hsv;
               sh_en[i]  <= 1'b1;
            end else if (cfg_we && cfg_sel == 3'(i)) begin
               sh_hsv[i] <= cfg_hsv;
               sh_en[i]  <= cfg_en;
            end
         end
         if (swap_q) begin
            act_hsv <= sh_hsv;
            act_en  <= sh_en;
            act_thr <= {thr_sum, thr_h, thr_s, thr_v};
         end
      end
   end

   logic [NUM_REF-1:0][DW-1:0]   dh_n, ds_n, dv_n, dh_s1, ds_s1, dv_s1;
   logic [NUM_REF-1:0][DW-1:0]   wh_n, ws_n, wv_n, wh_s2, ws_s2, wv_s2;
   logic [NUM_REF-1:0][DW+1:0]   sum_n, sum_s2;
   logic [NUM_REF-1:0]           en_s1, en_s2, match_n;
   logic [2:0]                   idx_n;
   thr_t                         thr_s1, thr_s2;
   logic                         v_s1, vs_s1, hs_s1, v_s2, vs_s2, hs_s2;

   always_comb begin
      dh_n = '0;
      ds_n = '0;
      dv_n = '0;
      for (int i = 0; i < NUM_REF; i++) begin
         dh_n[i] = absdiff(act_hsv[i][3*DW-1 -: DW], vid.in_hsv[3*DW-1 -: DW]);
         if ({1'b0, dh_n[i]} > HALF)
            dh_n[i] = DW'(HMOD - {1'b0, dh_n[i]});
         ds_n[i] = absdiff(act_hsv[i][2*DW-1 -: DW], vid.in_hsv[2*DW-1 -: DW]);
         dv_n[i] = absdiff(act_hsv[i][DW-1:0], vid.in_hsv[DW-1:0]);
      end
   end

   always_comb begin
      wh_n  = '0;
      ws_n  = '0;
      wv_n  = '0;
      sum_n = '0;
      for (int i = 0; i < NUM_REF; i++) begin
         wh_n[i]  = dh_s1[i] >> H_SHIFT;
         ws_n[i]  = ds_s1[i] >> SV_SHIFT;
         wv_n[i]  = dv_s1[i] >> SV_SHIFT;
         sum_n[i] = {2'b00, wh_n[i]} + {2'b00, ws_n[i]} + {2'b00, wv_n[i]};
      end
   end

   always_comb begin
      match_n = '0;
      idx_n   = '0;
      for (int i = 0; i < NUM_REF; i++)
         match_n[i] = en_s2[i] && (sum_s2[i] <= thr_s2.sum) && (wh_s2[i] <= thr_s2.h)
                      && (ws_s2[i] <= thr_s2.s) && (wv_s2[i] <= thr_s2.v);
      for (int i = NUM_REF - 1; i >= 0; i--)
         if (match_n[i])
            idx_n = 3'(i);
   end

   // Enables and thresholds travel with the pixel so a bank swap never splits one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dh_s1 <= '0; ds_s1 <= '0; dv_s1 <= '0; en_s1 <= '0; thr_s1 <= '0;
         v_s1  <= 1'b0; vs_s1 <= 1'b0; hs_s1 <= 1'b0;
         wh_s2 <= '0; ws_s2 <= '0; wv_s2 <= '0; sum_s2 <= '0; en_s2 <= '0; thr_s2 <= '0;
         v_s2  <= 1'b0; vs_s2 <= 1'b0; hs_s2 <= 1'b0;
         vid.out_valid <= 1'b0;
         vid.out_vs    <= 1'b0;
         vid.out_hs    <= 1'b0;
         vid.out_bin   <= 1'b0;
         vid.out_match <= '0;
         vid.out_idx   <= '0;
      end else begin
         dh_s1  <= dh_n;
         ds_s1  <= ds_n;
         dv_s1  <= dv_n;
         en_s1  <= act_en;
         thr_s1 <= act_thr;
         v_s1   <= vid.in_valid;
         vs_s1  <= vid.in_vs;
         hs_s1  <= vid.in_hs;
         wh_s2  <= wh_n;
         ws_s2  <= ws_n;
         wv_s2  <= wv_n;
         sum_s2 <= sum_n;
         en_s2  <= en_s1;
         thr_s2 <= thr_s1;
         v_s2   <= v_s1;
         vs_s2  <= vs_s1;
         hs_s2  <= hs_s1;
         vid.out_valid <= v_s2;
         vid.out_vs    <= vs_s2;
         vid.out_hs    <= hs_s2;
         vid.out_bin   <= v_s2 & (|match_n);
         vid.out_match <= v_s2 ? match_n : '0;
         vid.out_idx   <= v_s2 ? idx_n : '0;
      end
   end
endmodule

// File: tb/tb_hsv_match_multi.sv
// Directed bench for hsv_match_multi: matching, hue wrap, bank swap, learn, reset.
module tb_hsv_match_multi;
   localparam int NUM_REF = 4;
   localparam int DW      = 8;
   localparam int XW      = 11;
   localparam int YW      = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hsv_match_multi_if #(.NUM_REF(NUM_REF), .DW(DW)) vid ();

   logic              cfg_we, cfg_en, learn_req;
   logic [2:0]        cfg_idx, learn_idx;
   logic [3*DW-1:0]   cfg_hsv;
   logic [DW+1:0]     thr_sum;
   logic [DW-1:0]     thr_h, thr_s, thr_v;
   logic [XW-1:0]     learn_x;
   logic [YW-1:0]     learn_y;
   logic              learn_busy, learn_done;

   int checks = 0;
   int errors = 0;

   // {out_valid, out_bin, out_match[3:0], out_idx[2:0]}
   logic [8:0] obs;
   assign obs = {vid.out_valid, vid.out_bin, vid.out_match, vid.out_idx};

   hsv_match_multi #(.NUM_REF(NUM_REF), .DW(DW), .HUE_MOD(256), .H_SHIFT(1),
                     .SV_SHIFT(2), .XW(XW), .YW(YW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vid        (vid.slave),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_hsv    (cfg_hsv),
      .cfg_en     (cfg_en),
      .thr_sum    (thr_sum),
      .thr_h      (thr_h),
      .thr_s      (thr_s),
      .thr_v      (thr_v),
      .learn_req  (learn_req),
      .learn_idx  (learn_idx),
      .learn_x    (learn_x),
      .learn_y    (learn_y),
      .learn_busy (learn_busy),
      .learn_done (learn_done)
   );

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vid.in_valid = 1'b0;
         vid.in_vs    = 1'b0;
         vid.in_hs    = 1'b0;
         cfg_we       = 1'b0;
         learn_req    = 1'b0;
      end
   endtask

   task automatic send_pix(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
      @(negedge clk);
      vid.in_valid = 1'b1;
      vid.in_vs    = 1'b0;
      vid.in_hs    = 1'b0;
      vid.in_hsv   = {h, s, v};
      cfg_we       = 1'b0;
      learn_req    = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] idx, input logic [7:0] h, input logic [7:0] s,
                            input logic [7:0] v, input logic en);
      @(negedge clk);
      vid.in_valid = 1'b0;
      vid.in_vs    = 1'b0;
      vid.in_hs    = 1'b0;
      cfg_we       = 1'b1;
      cfg_idx      = idx;
      cfg_hsv      = {h, s, v};
      cfg_en       = en;
      learn_req    = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      vid.in_valid = 1'b0;
      vid.in_vs    = 1'b1;
      vid.in_hs    = 1'b0;
      cfg_we       = 1'b0;
      learn_req    = 1'b0;
      idle(3);
      @(negedge clk);
      vid.in_hs = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (obs !== 9'b0) begin errors++; $display("FAIL reset_outputs got %b exp %b", obs, 9'b0); end
      checks++;
      if ({learn_busy, learn_done} !== 2'b00) begin
         errors++; $display("FAIL reset_learn got %b exp 00", {learn_busy, learn_done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      checks++;
      if (obs !== 9'b0) begin errors++; $display("FAIL reset_idle got %b exp %b", obs, 9'b0); end
      frame_start();
      send_pix(8'd100, 8'd128, 8'd128);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL reset_disabled got %b exp %b", obs, 9'b1_0_0000_000);
      end
   endtask

   task automatic test_single();
      cfg_write(3'd0, 8'd100, 8'd128, 8'd128, 1'b1);
      frame_start();
      send_pix(8'd110, 8'd128, 8'd128);
      idle(2);
      checks++;
      if (obs !== 9'b0) begin errors++; $display("FAIL single_latency2 got %b exp %b", obs, 9'b0); end
      idle(1);
      checks++;
      if (obs !== 9'b1_1_0001_000) begin
         errors++; $display("FAIL single_match got %b exp %b", obs, 9'b1_1_0001_000);
      end
      send_pix(8'd114, 8'd128, 8'd128);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL single_wh7 got %b exp %b", obs, 9'b1_0_0000_000);
      end
   endtask

   task automatic test_hue_wrap();
      cfg_write(3'd0, 8'd250, 8'd128, 8'd128, 1'b1);
      frame_start();
      send_pix(8'd4, 8'd128, 8'd128);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_0001_000) begin
         errors++; $display("FAIL hue_wrap_near got %b exp %b", obs, 9'b1_1_0001_000);
      end
      send_pix(8'd20, 8'd128, 8'd128);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL hue_wrap_far got %b exp %b", obs, 9'b1_0_0000_000);
      end
   endtask

   task automatic test_two_targets();
      cfg_write(3'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      cfg_write(3'd1, 8'd60, 8'd100, 8'd100, 1'b1);
      cfg_write(3'd3, 8'd64, 8'd100, 8'd100, 1'b1);
      frame_start();
      send_pix(8'd62, 8'd100, 8'd100);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_1010_001) begin
         errors++; $display("FAIL two_both got %b exp %b", obs, 9'b1_1_1010_001);
      end
      cfg_write(3'd1, 8'd60, 8'd100, 8'd100, 1'b0);
      idle(1);
      send_pix(8'd62, 8'd100, 8'd100);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_1010_001) begin
         errors++; $display("FAIL two_midframe got %b exp %b", obs, 9'b1_1_1010_001);
      end
      frame_start();
      send_pix(8'd62, 8'd100, 8'd100);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_1000_011) begin
         errors++; $display("FAIL two_after_vs got %b exp %b", obs, 9'b1_1_1000_011);
      end
   endtask

   task automatic test_sum_boundary();
      cfg_write(3'd0, 8'd100, 8'd100, 8'd100, 1'b1);
      cfg_write(3'd3, 8'd64, 8'd100, 8'd100, 1'b0);
      frame_start();
      send_pix(8'd112, 8'd148, 8'd108);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_0001_000) begin
         errors++; $display("FAIL sum_eq20 got %b exp %b", obs, 9'b1_1_0001_000);
      end
      send_pix(8'd112, 8'd148, 8'd112);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL sum_21 got %b exp %b", obs, 9'b1_0_0000_000);
      end
      send_pix(8'd100, 8'd152, 8'd100);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL ws_13 got %b exp %b", obs, 9'b1_0_0000_000);
      end
   endtask

   task automatic test_learn();
      @(negedge clk);
      vid.in_valid = 1'b0;
      learn_req    = 1'b1;
      learn_idx    = 3'd2;
      learn_x      = XW'(5);
      learn_y      = YW'(3);
      idle(1);
      checks++;
      if ({learn_busy, learn_done} !== 2'b10) begin
         errors++; $display("FAIL learn_armed got %b exp 10", {learn_busy, learn_done});
      end
      @(negedge clk);
      vid.in_vs = 1'b1;
      idle(3);
      for (int y = 0; y < 4; y++) begin
         @(negedge clk);
         vid.in_valid = 1'b0;
         vid.in_hs    = 1'b1;
         for (int x = 0; x < ((y == 3) ? 6 : 8); x++) begin
            @(negedge clk);
            vid.in_hs    = 1'b0;
            vid.in_valid = 1'b1;
            cfg_we       = 1'b0;
            if (y == 3 && x == 5) begin
               vid.in_hsv = {8'd40, 8'd200, 8'd90};
               cfg_we     = 1'b1;
               cfg_idx    = 3'd2;
               cfg_hsv    = {8'd1, 8'd2, 8'd3};
               cfg_en     = 1'b0;
            end else begin
               vid.in_hsv = {8'(x * 16), 8'(y), 8'd0};
            end
         end
         if (y == 2) begin
            checks++;
            if (learn_busy !== 1'b1) begin
               errors++; $display("FAIL learn_early got busy=%b exp 1", learn_busy);
            end
         end
      end
      idle(1);
      checks++;
      if ({learn_busy, learn_done} !== 2'b01) begin
         errors++; $display("FAIL learn_done_pulse got %b exp 01", {learn_busy, learn_done});
      end
      idle(1);
      checks++;
      if ({learn_busy, learn_done} !== 2'b00) begin
         errors++; $display("FAIL learn_done_clear got %b exp 00", {learn_busy, learn_done});
      end
      frame_start();
      send_pix(8'd40, 8'd200, 8'd90);
      idle(3);
      checks++;
      if (obs !== 9'b1_1_0100_010) begin
         errors++; $display("FAIL learn_match got %b exp %b", obs, 9'b1_1_0100_010);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      vid.in_valid = 1'b0;
      learn_req    = 1'b1;
      learn_idx    = 3'd1;
      learn_x      = XW'(100);
      learn_y      = YW'(50);
      repeat (4) send_pix(8'd40, 8'd200, 8'd90);
      checks++;
      if (obs !== 9'b1_1_0100_010 || learn_busy !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre got %b busy=%b exp %b busy=1", obs, learn_busy, 9'b1_1_0100_010);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 9'b0 || learn_busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got %b busy=%b exp %b busy=0", obs, learn_busy, 9'b0);
      end
      @(negedge clk);
      rst_n        = 1'b1;
      vid.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         checks++;
         if (obs !== 9'b0) begin
            errors++; $display("FAIL rstmid_stale cycle %0d got %b exp %b", i, obs, 9'b0);
         end
      end
      frame_start();
      send_pix(8'd40, 8'd200, 8'd90);
      idle(3);
      checks++;
      if (obs !== 9'b1_0_0000_000) begin
         errors++; $display("FAIL rstmid_disabled got %b exp %b", obs, 9'b1_0_0000_000);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vid.in_valid = 1'b0;
      vid.in_vs    = 1'b0;
      vid.in_hs    = 1'b0;
      vid.in_hsv   = '0;
      cfg_we       = 1'b0;
      cfg_idx      = '0;
      cfg_hsv      = '0;
      cfg_en       = 1'b0;
      learn_req    = 1'b0;
      learn_idx    = '0;
      learn_x      = '0;
      learn_y      = '0;
      thr_sum      = 10'd20;
      thr_h        = 8'd6;
      thr_s        = 8'd12;
      thr_v        = 8'd12;
      repeat (3) @(negedge clk);
      test_reset();
      test_single();
      test_hue_wrap();
      test_two_targets();
      test_sum_boundary();
      test_learn();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
